// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and the responder FSM state type.
// Both the SRAM responder and the DMA bridges import this package.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HWORD = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } slave_state_e;

    // Lane enables for an aligned access of the given size.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << addr_lo;
            2'd1:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/sram_1r1w_be.sv
// 32-bit wide SRAM with one registered read port and one byte-enabled write port.
// Reads see the contents from before a same-edge write; forwarding is done by the caller.
module sram_1r1w_be #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wbe,
    input  logic [31:0]   wdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && wbe[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // The array itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite responder on top of a byte-enabled SRAM, with programmable
// wait states, two-cycle ERROR response and write-to-read forwarding.
module ahb3lite_sram_slave
    import ahb3lite_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sHSEL,
    input  logic [31:0] sHADDR,
    input  logic [31:0] sHWDATA,
    output logic [31:0] sHRDATA,
    input  logic        sHWRITE,
    input  logic [2:0]  sHSIZE,
    input  logic [2:0]  sHBURST,
    input  logic [3:0]  sHPROT,
    input  logic [1:0]  sHTRANS,
    output logic        sHREADYOUT,
    input  logic        sHREADY,
    output logic        sHRESP
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    slave_state_e  state, state_next;
    logic [2:0]    count, count_next;
    logic          ready_q, resp_q;

    logic [AW-1:0] word_q;
    logic [1:0]    lo_q;
    logic [1:0]    size_q;
    logic          write_q;

    logic          accept, take, addr_err;
    logic          rd_en, wr_en, hazard;
    logic [3:0]    wr_be, fwd_be_q;
    logic [31:0]   mem_rdata, fwd_data_q;

    logic          unused_bits;
    assign unused_bits = ^{sHBURST, sHPROT, sHTRANS[0]};

    assign accept = sHSEL & sHREADY & sHTRANS[1];
    // A new address phase can only land when the current data phase is finishing.
    assign take   = accept && (state == ST_IDLE || state == ST_LAST || state == ST_ERR2);

    always_comb begin
        addr_err = 1'b0;
        if ({2'b00, sHADDR[31:2]} >= 32'(MEM_DEPTH)) addr_err = 1'b1;
        if (sHSIZE > HSIZE_WORD)                      addr_err = 1'b1;
        if (sHSIZE == HSIZE_HWORD && sHADDR[0])       addr_err = 1'b1;
        if (sHSIZE == HSIZE_WORD && sHADDR[1:0] != 2'b00) addr_err = 1'b1;
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            ST_WAIT: begin
                if (count == 3'd1) begin
                    state_next = ST_LAST;
                    count_next = '0;
                end else begin
                    count_next = count - 3'd1;
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            default: begin
                state_next = ST_IDLE;
                if (take) begin
                    if (addr_err) begin
                        state_next = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_next = ST_LAST;
                    end else begin
                        state_next = ST_WAIT;
                        count_next = 3'(WAIT_STATES);
                    end
                end
            end
        endcase
    end

    // Handshake outputs are registered from the next state so they are glitch free.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            count   <= '0;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
        end else begin
            state   <= state_next;
            count   <= count_next;
            ready_q <= !(state_next == ST_WAIT || state_next == ST_ERR1);
            resp_q  <= (state_next == ST_ERR1 || state_next == ST_ERR2);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q  <= '0;
            lo_q    <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else if (take) begin
            word_q  <= sHADDR[AW+1:2];
            lo_q    <= sHADDR[1:0];
            size_q  <= sHSIZE[1:0];
            write_q <= sHWRITE;
        end
    end

    assign wr_be  = byte_enable(size_q, lo_q);
    assign wr_en  = (state == ST_LAST) && write_q && !rst_i;
    assign rd_en  = take && !sHWRITE && !addr_err;
    assign hazard = wr_en && (word_q == sHADDR[AW+1:2]);

    // Lanes written on the same edge as the read are captured here and merged on output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fwd_be_q   <= '0;
            fwd_data_q <= '0;
        end else if (rd_en) begin
            fwd_be_q   <= hazard ? wr_be : 4'h0;
            fwd_data_q <= sHWDATA;
        end
    end

    sram_1r1w_be #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk   (clk_i),
        .rst   (rst_i),
        .re    (rd_en),
        .raddr (sHADDR[AW+1:2]),
        .rdata (mem_rdata),
        .we    (wr_en),
        .waddr (word_q),
        .wbe   (wr_be),
        .wdata (sHWDATA)
    );

    always_comb begin
        sHRDATA = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (fwd_be_q[i]) sHRDATA[8*i +: 8] = fwd_data_q[8*i +: 8];
        end
    end

    assign sHREADYOUT = ready_q;
    assign sHRESP     = resp_q;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench for ahb3lite_sram_slave: a one-wait-state instance driven from a
// vector table plus hand sequences, and a zero-wait instance for pipelined forwarding.
module tb_ahb3lite_sram_slave;
    import ahb3lite_pkg::*;

    localparam int unsigned DEPTH = 64;

    typedef struct {
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_data;
        logic [31:0] rdata;
        logic        resp;
        int          cycles;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int assertions = 0;
    int failures   = 0;

    logic        a_sel, a_write, a_readyout, a_resp;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [2:0]  a_size;
    logic [1:0]  a_trans;

    logic        b_sel, b_write, b_readyout, b_resp;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [2:0]  b_size;
    logic [1:0]  b_trans;

    ahb3lite_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(1)) dut_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .sHSEL      (a_sel),
        .sHADDR     (a_addr),
        .sHWDATA    (a_wdata),
        .sHRDATA    (a_rdata),
        .sHWRITE    (a_write),
        .sHSIZE     (a_size),
        .sHBURST    (3'b000),
        .sHPROT     (4'b0011),
        .sHTRANS    (a_trans),
        .sHREADYOUT (a_readyout),
        .sHREADY    (a_readyout),
        .sHRESP     (a_resp)
    );

    ahb3lite_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .sHSEL      (b_sel),
        .sHADDR     (b_addr),
        .sHWDATA    (b_wdata),
        .sHRDATA    (b_rdata),
        .sHWRITE    (b_write),
        .sHSIZE     (b_size),
        .sHBURST    (3'b000),
        .sHPROT     (4'b0011),
        .sHTRANS    (b_trans),
        .sHREADYOUT (b_readyout),
        .sHREADY    (b_readyout),
        .sHRESP     (b_resp)
    );

    vec_t vecs [20];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One complete transfer on instance A; starts and ends just after a rising edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        int cycles;
        int resp_cycles;
        logic done;
        a_sel   = 1'b1;
        a_trans = HTRANS_NONSEQ;
        a_addr  = v.addr;
        a_write = v.write;
        a_size  = v.size;
        @(posedge clk); #1;
        a_sel   = 1'b0;
        a_trans = HTRANS_IDLE;
        a_wdata = v.wdata;
        cycles = 0;
        resp_cycles = 0;
        done = 1'b0;
        while (!done && cycles < 10) begin
            @(negedge clk);
            cycles++;
            if (a_resp === 1'b1) resp_cycles++;
            if (a_readyout === 1'b1) begin
                done = 1'b1;
                checkOutput($sformatf("v%0d_resp", idx), 32'(a_resp), 32'(v.resp));
                if (v.chk_data) checkOutput($sformatf("v%0d_rdata", idx), a_rdata, v.rdata);
            end
            @(posedge clk); #1;
        end
        checkOutput($sformatf("v%0d_cycles", idx), 32'(cycles), 32'(v.cycles));
        checkOutput($sformatf("v%0d_resp_cycles", idx), 32'(resp_cycles), v.resp ? 32'd2 : 32'd0);
    endtask

    initial begin
        vec_t v;
        logic [1:0] pat_trans [3];
        logic       pat_sel [3];

        //            wr    size         addr        wdata          chk   rdata          resp         cyc
        vecs[0]  = '{1'b1, HSIZE_WORD,  32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        HRESP_OKAY,  2};
        vecs[1]  = '{1'b0, HSIZE_WORD,  32'h10,  32'h0,        1'b1, 32'hDEADBEEF, HRESP_OKAY,  2};
        vecs[2]  = '{1'b1, HSIZE_WORD,  32'h20,  32'h00000000, 1'b0, 32'h0,        HRESP_OKAY,  2};
        vecs[3]  = '{1'b1, HSIZE_BYTE,  32'h21,  32'hAAAAAAAA, 1'b0, 32'h0,        HRESP_OKAY,  2};
        vecs[4]  = '{1'b1, HSIZE_HWORD, 32'h22,  32'h55555555, 1'b0, 32'h0,        HRESP_OKAY,  2};
        vecs[5]  = '{1'b0, HSIZE_WORD,  32'h20,  32'h0,        1'b1, 32'h5555AA00, HRESP_OKAY,  2};
        vecs[6]  = '{1'b0, HSIZE_BYTE,  32'h21,  32'h0,        1'b1, 32'h5555AA00, HRESP_OKAY,  2};
        vecs[7]  = '{1'b1, HSIZE_WORD,  32'h00,  32'h0BADF00D, 1'b0, 32'h0,        HRESP_OKAY,  2};
        vecs[8]  = '{1'b1, HSIZE_WORD,  32'h80,  32'h11223344, 1'b0, 32'h0,        HRESP_OKAY,  2};
        vecs[9]  = '{1'b0, HSIZE_WORD,  32'h02,  32'h0,        1'b0, 32'h0,        HRESP_ERROR, 2};
        vecs[10] = '{1'b0, HSIZE_HWORD, 32'h01,  32'h0,        1'b0, 32'h0,        HRESP_ERROR, 2};
        vecs[11] = '{1'b0, 3'd3,        32'h10,  32'h0,        1'b0, 32'h0,        HRESP_ERROR, 2};
        vecs[12] = '{1'b0, HSIZE_WORD,  32'h100, 32'h0,        1'b0, 32'h0,        HRESP_ERROR, 2};
        vecs[13] = '{1'b1, HSIZE_WORD,  32'h100, 32'hFFFFFFFF, 1'b0, 32'h0,        HRESP_ERROR, 2};
        vecs[14] = '{1'b1, HSIZE_WORD,  32'h12,  32'hFFFFFFFF, 1'b0, 32'h0,        HRESP_ERROR, 2};
        vecs[15] = '{1'b1, HSIZE_HWORD, 32'h11,  32'hFFFFFFFF, 1'b0, 32'h0,        HRESP_ERROR, 2};
        vecs[16] = '{1'b0, HSIZE_WORD,  32'h00,  32'h0,        1'b1, 32'h0BADF00D, HRESP_OKAY,  2};
        vecs[17] = '{1'b0, HSIZE_WORD,  32'h10,  32'h0,        1'b1, 32'hDEADBEEF, HRESP_OKAY,  2};
        vecs[18] = '{1'b1, HSIZE_WORD,  32'hFC,  32'hA5A5A5A5, 1'b0, 32'h0,        HRESP_OKAY,  2};
        vecs[19] = '{1'b0, HSIZE_WORD,  32'hFC,  32'h0,        1'b1, 32'hA5A5A5A5, HRESP_OKAY,  2};

        rst = 1'b1;
        a_sel = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0; a_size = HSIZE_WORD; a_trans = HTRANS_IDLE;
        b_sel = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0; b_size = HSIZE_WORD; b_trans = HTRANS_IDLE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_a_ready", 32'(a_readyout), 32'd1);
        checkOutput("rst_a_resp",  32'(a_resp),     32'd0);
        checkOutput("rst_a_rdata", a_rdata,         32'h0);
        checkOutput("rst_b_ready", 32'(b_readyout), 32'd1);
        checkOutput("rst_b_rdata", b_rdata,         32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] vector table on one-wait-state instance");
        for (int i = 0; i < 20; i++) applyStimulus(vecs[i], i);

        $display("[TB] idle, busy and deselected transfers");
        pat_sel[0] = 1'b1; pat_trans[0] = HTRANS_IDLE;
        pat_sel[1] = 1'b1; pat_trans[1] = HTRANS_BUSY;
        pat_sel[2] = 1'b0; pat_trans[2] = HTRANS_NONSEQ;
        for (int p = 0; p < 3; p++) begin
            a_sel = pat_sel[p]; a_trans = pat_trans[p];
            a_write = 1'b1; a_size = HSIZE_WORD; a_addr = 32'h10; a_wdata = 32'hFFFFFFFF;
            @(posedge clk); #1;
            a_sel = 1'b0; a_trans = HTRANS_IDLE;
            @(negedge clk);
            checkOutput($sformatf("noxfer%0d_ready", p), 32'(a_readyout), 32'd1);
            checkOutput($sformatf("noxfer%0d_resp", p),  32'(a_resp),     32'd0);
            @(posedge clk); #1;
        end
        v = '{1'b0, HSIZE_WORD, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, HRESP_OKAY, 2};
        applyStimulus(v, 20);

        $display("[TB] reset during write wait state");
        a_sel = 1'b1; a_trans = HTRANS_NONSEQ; a_write = 1'b1; a_size = HSIZE_WORD; a_addr = 32'h80;
        @(posedge clk); #1;
        a_sel = 1'b0; a_trans = HTRANS_IDLE; a_wdata = 32'hCAFEBABE;
        @(negedge clk);
        checkOutput("rstwr_wait_ready", 32'(a_readyout), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstwr_ready", 32'(a_readyout), 32'd1);
        checkOutput("rstwr_resp",  32'(a_resp),     32'd0);
        checkOutput("rstwr_rdata", a_rdata,         32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        v = '{1'b0, HSIZE_WORD, 32'h80, 32'h0, 1'b1, 32'h11223344, HRESP_OKAY, 2};
        applyStimulus(v, 21);

        $display("[TB] zero-wait pipelined write then read with forwarding");
        b_sel = 1'b1; b_trans = HTRANS_NONSEQ; b_write = 1'b1; b_size = HSIZE_WORD; b_addr = 32'h40;
        @(posedge clk); #1;
        b_wdata = 32'h12345678; b_write = 1'b0;
        @(negedge clk);
        checkOutput("b2b_wr_ready", 32'(b_readyout), 32'd1);
        @(posedge clk); #1;
        b_sel = 1'b0; b_trans = HTRANS_IDLE;
        @(negedge clk);
        checkOutput("b2b_rd_ready", 32'(b_readyout), 32'd1);
        checkOutput("b2b_rd_resp",  32'(b_resp),     32'd0);
        checkOutput("b2b_rd_rdata", b_rdata,         32'h12345678);
        @(posedge clk); #1;

        b_sel = 1'b1; b_trans = HTRANS_NONSEQ; b_write = 1'b1; b_size = HSIZE_BYTE; b_addr = 32'h41;
        @(posedge clk); #1;
        b_wdata = 32'hEEEEEEEE; b_write = 1'b0; b_size = HSIZE_WORD; b_addr = 32'h40;
        @(negedge clk);
        checkOutput("b2b_byte_ready", 32'(b_readyout), 32'd1);
        @(posedge clk); #1;
        b_sel = 1'b0; b_trans = HTRANS_IDLE;
        @(negedge clk);
        checkOutput("b2b_merge_rdata", b_rdata, 32'h1234EE78);
        checkOutput("b2b_merge_ready", 32'(b_readyout), 32'd1);
        @(posedge clk); #1;

        b_sel = 1'b1; b_trans = HTRANS_NONSEQ; b_write = 1'b0; b_addr = 32'h40;
        @(posedge clk); #1;
        b_sel = 1'b0; b_trans = HTRANS_IDLE;
        @(negedge clk);
        checkOutput("b_mem_rdata", b_rdata, 32'h1234EE78);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
